// File: rtl/dual_view_pkg.sv
// Shared layout modes, default geometry and pixel-format helper for the
// dual-camera HDMI read scheduler.
package dual_view_pkg;

   typedef enum logic [1:0] {
      MODE_SBS   = 2'd0,
      MODE_CH0   = 2'd1,
      MODE_CH1   = 2'd2,
      MODE_BLANK = 2'd3
   } view_mode_e;

   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_SPLIT_X  = 640;

   // Widen each colour field by repeating its top bits into the new LSBs.
   function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
      return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Resettable fixed-depth shift register; a value entering on one edge
// leaves DEPTH edges later.
module sync_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dual_view_read_sched.sv
// Per-pixel read scheduler between the HDMI timing generator and the two
// camera read FIFOs; i_data_16 packs channel 1 in [31:16], channel 0 in [15:0].
module dual_view_read_sched
   import dual_view_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int SPLIT_X    = DEF_SPLIT_X,
   parameter int RD_LAT     = 1,
   parameter int RST_CYCLES = 8,
   parameter bit VS_POL     = 1'b1
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic [1:0]  i_mode,
   input  logic        i_video_hs,
   input  logic        i_video_vs,
   input  logic        i_video_de,
   output logic        o_read_rst,
   output logic [1:0]  o_data_req,
   input  logic [1:0]  i_fifo_empty,
   input  logic [31:0] i_data_16,
   output logic        o_video_hs,
   output logic        o_video_vs,
   output logic        o_video_de,
   output logic [23:0] o_video_rgb,
   output logic [1:0]  o_underflow,
   input  logic        i_clr_status
);

   localparam int XW = $clog2(H_ACTIVE);
   localparam int RW = $clog2(RST_CYCLES + 1);
   localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
   localparam logic [XW-1:0] X_SPLIT  = XW'(SPLIT_X);
   localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

   logic            vs_act;
   logic            vs_act_q;
   logic            frame_start;
   logic            rst_next;
   view_mode_e      mode_q;
   logic [RW-1:0]   rst_cnt;
   logic [XW-1:0]   x_q;
   logic [1:0]      req_next;
   logic            pix_ok;
   logic            pix_sel;
   logic [15:0]     pix_data;

   assign vs_act      = (i_video_vs == VS_POL);
   assign frame_start = vs_act & ~vs_act_q;
   // Value o_read_rst takes after this edge, so requests are gated in lockstep.
   assign rst_next    = frame_start | (o_read_rst & (rst_cnt != '0));

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         vs_act_q   <= 1'b0;
         mode_q     <= MODE_BLANK;
         rst_cnt    <= '0;
         o_read_rst <= 1'b0;
      end else begin
         vs_act_q   <= vs_act;
         o_read_rst <= rst_next;
         if (frame_start) begin
            mode_q  <= view_mode_e'(i_mode);
            rst_cnt <= RST_LOAD;
         end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         x_q <= '0;
      end else if (!i_video_de) begin
         x_q <= '0;
      end else if (x_q != X_LAST) begin
         x_q <= x_q + 1'b1;
      end
   end

   always_comb begin
      req_next = 2'b00;
      if (i_video_de && !rst_next) begin
         case (mode_q)
            MODE_SBS: req_next = (x_q >= X_SPLIT) ? 2'b10 : 2'b01;
            MODE_CH0: req_next = 2'b01;
            MODE_CH1: req_next = 2'b10;
            default:  req_next = 2'b00;
         endcase
      end
   end

   // A simultaneous new underflow outranks the status clear.
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         o_data_req  <= 2'b00;
         o_underflow <= 2'b00;
      end else begin
         o_data_req  <= req_next;
         o_underflow <= (o_underflow & ~{2{i_clr_status}}) | (o_data_req & i_fifo_empty);
      end
   end

   sync_delay_line #(.WIDTH(2), .DEPTH(RD_LAT)) u_sel_line (
      .clk  (i_sys_clk),
      .rst  (i_sys_rst),
      .din  ({|(o_data_req & ~i_fifo_empty), o_data_req[1]}),
      .dout ({pix_ok, pix_sel})
   );

   sync_delay_line #(.WIDTH(3), .DEPTH(RD_LAT + 2)) u_sync_line (
      .clk  (i_sys_clk),
      .rst  (i_sys_rst),
      .din  ({i_video_hs, i_video_vs, i_video_de}),
      .dout ({o_video_hs, o_video_vs, o_video_de})
   );

   assign pix_data = pix_sel ? i_data_16[31:16] : i_data_16[15:0];

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         o_video_rgb <= '0;
      end else begin
         o_video_rgb <= pix_ok ? rgb565_to_888(pix_data) : 24'h000000;
      end
   end

endmodule

// File: tb/tb_dual_view_read_sched.sv
// Self-checking bench: directed scenarios plus randomized frames compared
// cycle by cycle against a history-based reference model.
module tb_dual_view_read_sched;

   localparam int H_ACTIVE   = 1280;
   localparam int SPLIT_X    = 640;
   localparam int RD_LAT     = 1;
   localparam int RST_CYCLES = 8;
   localparam bit VS_POL     = 1'b1;
   localparam int MAXC       = 65536;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
   logic [1:0]  empty = 2'b00;
   logic [31:0] data = 32'h0;
   logic        clr = 1'b0;

   logic        read_rst;
   logic [1:0]  req;
   logic        vhs, vvs, vde;
   logic [23:0] rgb;
   logic [1:0]  uf;

   dual_view_read_sched #(
      .H_ACTIVE(H_ACTIVE), .SPLIT_X(SPLIT_X), .RD_LAT(RD_LAT),
      .RST_CYCLES(RST_CYCLES), .VS_POL(VS_POL)
   ) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_mode(mode),
      .i_video_hs(hs), .i_video_vs(vs), .i_video_de(de),
      .o_read_rst(read_rst), .o_data_req(req),
      .i_fifo_empty(empty), .i_data_16(data),
      .o_video_hs(vhs), .o_video_vs(vvs), .o_video_de(vde),
      .o_video_rgb(rgb), .o_underflow(uf), .i_clr_status(clr)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dutPack();
      return {read_rst, req, vhs, vvs, vde, rgb, uf};
   endfunction

   function automatic logic [23:0] expand565(input logic [15:0] p);
      int r, g, b;
      r = int'(p) / 2048;
      g = (int'(p) / 32) % 64;
      b = int'(p) % 32;
      return 24'(((r * 8 + r / 4) * 65536) + ((g * 4 + g / 16) * 256) + (b * 8 + b / 4));
   endfunction

   // Reference model: decisions derived from input history since the last reset.
   logic        model_valid = 1'b0;
   logic [31:0] exp_pack = 32'h0;
   int          n = 0, e = 0, last_fs = -1000000, run = 0;
   logic        prev_vsa = 1'b0;
   logic [1:0]  mode_m = 2'd3, uf_m = 2'b00;
   logic [1:0]  req_a [MAXC];
   logic        ok_a  [MAXC];
   logic        sel_a [MAXC];
   logic [2:0]  vid_a [MAXC];

   always @(posedge clk) begin : model_proc
      logic vsa, fs, rst_m;
      logic [1:0] rq, rprev, dmode;
      logic [2:0] vid;
      logic [23:0] px;
      logic [15:0] dsel;
      int xpos, ri, vi;
      if (rst) begin
         e = n + 1; last_fs = -1000000; mode_m = 2'd3; run = 0;
         prev_vsa = 1'b0; uf_m = 2'b00; exp_pack = 32'h0; model_valid = 1'b1;
      end else begin
         vsa = (vs == VS_POL);
         fs = vsa && !prev_vsa;
         prev_vsa = vsa;
         dmode = mode_m;
         if (fs) begin
            last_fs = n;
            mode_m = mode;
         end
         rst_m = (n - last_fs) < RST_CYCLES;
         xpos = (run < H_ACTIVE) ? run : H_ACTIVE - 1;
         rq = 2'b00;
         if (de && !rst_m) begin
            if (dmode == 2'd0) rq = (xpos < SPLIT_X) ? 2'b01 : 2'b10;
            else if (dmode == 2'd1) rq = 2'b01;
            else if (dmode == 2'd2) rq = 2'b10;
         end
         run = de ? run + 1 : 0;
         rprev = (n - 1 >= e) ? req_a[(n - 1) % MAXC] : 2'b00;
         uf_m = (uf_m & ~{2{clr}}) | (rprev & empty);
         ok_a[n % MAXC]  = |(rprev & ~empty);
         sel_a[n % MAXC] = rprev[1];
         req_a[n % MAXC] = rq;
         vid_a[n % MAXC] = {hs, vs, de};
         px = 24'h0;
         ri = n - RD_LAT;
         if (ri >= e && ok_a[ri % MAXC]) begin
            dsel = sel_a[ri % MAXC] ? data[31:16] : data[15:0];
            px = expand565(dsel);
         end
         vi = n - RD_LAT - 1;
         vid = (vi >= e) ? vid_a[vi % MAXC] : 3'b000;
         exp_pack = {rst_m, rq, vid, px, uf_m};
      end
      n = n + 1;
   end

   always @(negedge clk) begin
      if (model_valid) checkOutput("cycle_model", dutPack(), exp_pack);
   end

   // Directed-scenario tallies gathered once per cycle.
   int cyc = 0, c_rst, c01, c10, c_bad, c_bad_total = 0, cr0, cr1, cz, c_nz;
   int de_out_cyc, line_start_cyc;
   logic seen_de;
   logic [23:0] tgt0 = 24'h0, tgt1 = 24'h0, last_rgb, first_rgb;

   task automatic clearTally();
      c_rst = 0; c01 = 0; c10 = 0; c_bad = 0; cr0 = 0; cr1 = 0; cz = 0; c_nz = 0;
      seen_de = 1'b0; de_out_cyc = 0; last_rgb = 24'h0; first_rgb = 24'h0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (read_rst) c_rst++;
      if (req == 2'b01) c01++;
      else if (req == 2'b10) c10++;
      else if (req == 2'b11) begin c_bad++; c_bad_total++; end
      if (vde) begin
         if (rgb == tgt0) cr0++;
         else if (rgb == tgt1) cr1++;
         else if (rgb == 24'h0) cz++;
         last_rgb = rgb;
         if (!seen_de) begin
            seen_de = 1'b1; de_out_cyc = cyc; first_rgb = rgb;
         end
      end
      if (rgb != 24'h0) c_nz++;
   endtask

   task automatic applyStimulus(input logic d, input logic [1:0] emp, input logic c);
      de = d; empty = emp; clr = c;
      step();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 2'b00, 1'b0);
   endtask

   task automatic vsPulse();
      vs = 1'b1;
      idle(2);
      vs = 1'b0;
   endtask

   task automatic line(input int len, input int uf_pix, input logic [1:0] uf_mask, input int clr_pix);
      line_start_cyc = cyc;
      for (int i = 0; i < len; i++)
         applyStimulus(1'b1,
                       (uf_pix >= 0 && i == uf_pix + 1) ? uf_mask : 2'b00,
                       (clr_pix >= 0 && i == clr_pix + 1));
   endtask

   typedef struct {
      logic [15:0] pix;
      logic [23:0] exp;
   } vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{16'hF800, 24'hFF0000};
      tbl[1] = '{16'h07E0, 24'h00FF00};
      tbl[2] = '{16'h001F, 24'h0000FF};
      tbl[3] = '{16'hFFFF, 24'hFFFFFF};
      tbl[4] = '{16'h0000, 24'h000000};
      tbl[5] = '{16'h8410, 24'h848284};
      tbl[6] = '{16'h0841, 24'h080808};
      tbl[7] = '{16'h7BEF, 24'h7B7D7B};

      clearTally();
      step(); step();
      checkOutput("reset_state", dutPack(), 32'h0);
      rst = 1'b0;

      // Blank until the first frame start
      clearTally();
      repeat (3) begin line(20, -1, 2'b00, -1); idle(5); end
      checkOutput("blank_req", c01 + c10 + c_bad, 0);
      checkOutput("blank_rgb", c_nz, 0);

      // Side-by-side line
      mode = 2'd0; data = {16'h001F, 16'hF800};
      tgt0 = 24'hFF0000; tgt1 = 24'h0000FF;
      clearTally();
      vsPulse(); idle(15);
      line(1280, -1, 2'b00, -1); idle(10);
      checkOutput("read_rst_len", c_rst, RST_CYCLES);
      checkOutput("sbs_ch0_req", c01, 640);
      checkOutput("sbs_ch1_req", c10, 640);
      checkOutput("sbs_ch0_rgb", cr0, 640);
      checkOutput("sbs_ch1_rgb", cr1, 640);
      checkOutput("de_latency", de_out_cyc - line_start_cyc, RD_LAT + 2);
      checkOutput("first_pixel", 32'(first_rgb), 32'hFF0000);

      // Mode change mid-line only takes effect at the next frame start
      clearTally();
      vsPulse(); idle(15);
      for (int i = 0; i < 1280; i++) begin
         if (i == 320) mode = 2'd1;
         applyStimulus(1'b1, 2'b00, 1'b0);
      end
      idle(10);
      checkOutput("midline_mode_hold", c10, 640);
      vsPulse(); idle(15);
      clearTally();
      line(1280, -1, 2'b00, -1); idle(10);
      checkOutput("ch0_full_req", c01, 1280);
      checkOutput("ch0_full_no_ch1", c10, 0);

      // RGB565 expansion table through channel 0
      for (int i = 0; i < 8; i++) begin
         data[15:0] = tbl[i].pix;
         clearTally();
         line(4, -1, 2'b00, -1); idle(6);
         checkOutput($sformatf("rgb_table_%0d", i), 32'(last_rgb), 32'(tbl[i].exp));
      end

      // Underflow on channel 1
      mode = 2'd2; data = {16'h07E0, 16'h0000};
      tgt0 = 24'h123456; tgt1 = 24'h00FF00;
      vsPulse(); idle(15);
      clearTally();
      line(1280, 100, 2'b10, -1); idle(10);
      checkOutput("uf_set", 32'(uf), 32'h2);
      checkOutput("uf_pixel_zero", cz, 1);
      checkOutput("uf_neighbours", cr1, 1279);
      idle(5);
      checkOutput("uf_sticky", 32'(uf), 32'h2);
      applyStimulus(1'b0, 2'b00, 1'b1);
      checkOutput("uf_clear", 32'(uf), 32'h0);
      line(200, 50, 2'b10, 50); idle(5);
      checkOutput("uf_clr_collide", 32'(uf), 32'h2);

      // DE overrun saturates on channel 1
      mode = 2'd0; data = {16'h001F, 16'hF800};
      tgt0 = 24'hFF0000; tgt1 = 24'h0000FF;
      vsPulse(); idle(15);
      clearTally();
      line(1400, -1, 2'b00, -1); idle(10);
      checkOutput("overrun_ch0", c01, 640);
      checkOutput("overrun_ch1", c10, 760);

      // Asynchronous reset in the middle of a line
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 2'b00, 1'b0);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset", dutPack(), 32'h0);
      step(); step();
      rst = 1'b0;
      clearTally();
      line(200, -1, 2'b00, -1); idle(5);
      checkOutput("no_req_after_reset", c01 + c10 + c_bad, 0);
      vsPulse(); idle(15);
      clearTally();
      line(50, -1, 2'b00, -1); idle(5);
      checkOutput("resume_after_vs", c01, 50);

      // Randomized frames against the reference model
      for (int f = 0; f < 4; f++) begin
         mode = 2'($urandom % 4);
         vsPulse();
         if ($urandom % 2 == 1) begin idle(3); vsPulse(); end
         idle(12);
         for (int l = 0; l < 3; l++) begin
            int len;
            len = $urandom_range(600, 1350);
            for (int i = 0; i < len; i++) begin
               logic [1:0] emp;
               data = $urandom;
               hs = 1'($urandom % 2);
               emp = {($urandom % 50) == 0, ($urandom % 50) == 0};
               if ($urandom % 400 == 0) mode = 2'($urandom % 4);
               applyStimulus(1'b1, emp, ($urandom % 150) == 0);
            end
            hs = 1'b1; idle(4); hs = 1'b0; idle(6);
         end
      end

      checkOutput("req_onehot", c_bad_total, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dual_view_read_sched.md
Name: dual_view_read_sched

Overview:
- Per-pixel scheduler between the HDMI timing generator and the two SDRAM read FIFOs (camera 0 and camera 1), in the pixel clock domain.
- Decides which FIFO is read on each active pixel according to a layout mode, and issues the per-frame FIFO read reset.
- Re-aligns sync/DE with the returned data and expands RGB565 to RGB888.
- Detects and reports FIFO underflow.

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- SPLIT_X, 640, first x position sourced from channel 1 in side-by-side mode.
- RD_LAT, 1, FIFO read latency in cycles from req to valid data (legal 1..3).
- RST_CYCLES, 8, length of the o_read_rst pulse per frame.
- VS_POL, 1, active polarity of i_video_vs.

Ports:
- i_sys_clk  in  1  pixel clock.
- i_sys_rst  in  1  asynchronous reset, active-high.
- i_mode  in  2  layout: 0 side-by-side, 1 ch0 full, 2 ch1 full, 3 blank (no reads).
- i_video_hs  in  1  hsync from timing generator.
- i_video_vs  in  1  vsync from timing generator.
- i_video_de  in  1  active video from timing generator.
- o_read_rst  out  1  FIFO read-side reset pulse.
- o_data_req  out  2  per-channel read request, one-hot or zero.
- i_fifo_empty  in  2  per-channel FIFO empty.
- i_data_16  in  2x16  per-channel RGB565 read data.
- o_video_hs  out  1  delayed hsync.
- o_video_vs  out  1  delayed vsync.
- o_video_de  out  1  delayed DE.
- o_video_rgb  out  24  RGB888 pixel.
- o_underflow  out  2  sticky per-channel underflow flag.
- i_clr_status  in  1  clears o_underflow.

Behaviour:
- Reset:
  - All outputs 0.
  - x counter 0, latched mode 3 (blank) until the first frame start.
  - rst counter 0.
  - Delay lines cleared.
- Frame start is the cycle where i_video_vs becomes active (edge detected against the registered previous value, XOR VS_POL).
- On frame start:
  - Latch i_mode into mode_q. i_mode changes take effect only here, so there is no mid-frame tearing.
  - Load rst counter with RST_CYCLES. o_read_rst is registered and is high for exactly RST_CYCLES cycles starting the cycle after the edge.
  - A new frame start during an active pulse reloads the counter.
- X counter:
  - Increments on each cycle with i_video_de=1.
  - Clears to 0 on the first cycle with de=0.
  - Saturates at H_ACTIVE-1 if DE is held longer.
- Request (registered, asserted the cycle after input DE):
  - Side-by-side: o_data_req = {x>=SPLIT_X, x<SPLIT_X}.
  - Mode 1: o_data_req = 2'b01. Mode 2: o_data_req = 2'b10.
  - Mode 3 and while o_read_rst=1: o_data_req = 0.
  - At most one bit is set in any cycle.
- Data path:
  - Channel select is delayed RD_LAT cycles alongside the request.
  - Data is sampled from the selected channel RD_LAT cycles after req and registered one more cycle.
  - RGB expansion: R = {r5, r5[4:2]}, G = {g6, g6[5:4]}, B = {b5, b5[4:2]}.
  - No request in flight (blank, reset window, or DE low) gives o_video_rgb = 0.
- Timing alignment:
  - hs/vs/de each pass through an RD_LAT+2 register line.
  - Input DE at cycle t appears on o_video_de at t+RD_LAT+2, together with its pixel.
- Underflow:
  - Any cycle where o_data_req[i]=1 and i_fifo_empty[i]=1 sets o_underflow[i].
  - The pixel output for that slot is forced to 0.
  - i_clr_status clears both flags; a simultaneous new underflow wins (flag stays 1).
- Asynchronous reset mid-line:
  - Everything returns to reset values immediately.
  - Scheduling resumes only after the next frame start (mode_q = blank until then).

Decomposition:
- Shared package dual_view_pkg holds:
  - Mode enum: MODE_SBS=0, MODE_CH0=1, MODE_CH1=2, MODE_BLANK=3.
  - rgb565_to_888 function.
  - Default H_ACTIVE/SPLIT_X constants.
- One sub-module, sync_delay_line (parameterised width/depth shift register), used for the timing line and the channel-select line.

Test Plan:
- Reset released, no vs edge, de toggling -> o_data_req stays 0, o_video_rgb=0 (mode blank).
- Mode 0, vs edge, 1280-cycle DE line -> o_read_rst high exactly 8 cycles; req=01 for x 0..639 and 10 for x 640..1279; ch0 data 16'hF800 gives output 24'hFF0000, ch1 data 16'h001F gives 24'h0000FF, appearing at o_video_de with 3-cycle latency (RD_LAT=1).
- i_mode changed 0->1 mid-line -> remainder of frame stays side-by-side; after the next vs edge req=01 for all 1280 pixels.
- Mode 2 with i_fifo_empty[1]=1 at x=100 -> o_underflow=2'b10 sticky, that pixel 0, neighbours correct; i_clr_status pulse clears it, and coincident with another underflow the flag remains 1.
- Overrun DE beyond 1280 cycles in mode 0 -> x saturates at 1279, req stays 10, no wrap to channel 0.
- Assert i_sys_rst at x=300 -> all outputs 0 within the same cycle; after release, no req until the next vs edge.
